// File: rtl/spi_reg_controller.sv
// SPI transaction controller: decodes a command byte per chip-select frame and
// streams bytes to/from a register bank with address auto-increment and read prefetch.
module spi_reg_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ssel,
    input  logic       byte_received,
    input  logic [7:0] received_data,
    output logic [7:0] data_to_send,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       txn_done
);

    localparam logic [7:0] StatusByte = 8'hA5;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StCmd    = 3'd1;
    localparam logic [2:0] StWr     = 3'd2;
    localparam logic [2:0] StRdReq  = 3'd3;
    localparam logic [2:0] StRdWait = 3'd4;
    localparam logic [2:0] StRd     = 3'd5;

    logic       ssel_meta_q, ssel_s_q;
    logic [2:0] state_q, state_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic [7:0] dts_q, dts_d;
    logic [6:0] reg_addr_q, reg_addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic       re_q, re_d;
    logic       done_q, done_d;

    logic [6:0] addr_inc;
    logic [6:0] rd_addr;
    logic [7:0] cnt_inc;

    assign addr_inc = addr_q + 7'd1;
    assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        dts_d      = dts_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        done_d     = 1'b0;
        rd_addr    = addr_q;

        case (state_q)
            StIdle: begin
                dts_d  = StatusByte;
                cnt_d  = 8'd0;
                pend_d = 1'b0;
                if (!ssel_s_q) state_d = StCmd;
            end
            StCmd: begin
                if (byte_received) begin
                    addr_d = received_data[6:0];
                    if (received_data[7]) begin
                        // Issue the first read right away so data is ready 3 clk later.
                        re_d       = 1'b1;
                        reg_addr_d = received_data[6:0];
                        state_d    = StRdReq;
                    end else begin
                        state_d = StWr;
                    end
                end
            end
            StWr: begin
                if (byte_received) begin
                    we_d       = 1'b1;
                    reg_addr_d = addr_q;
                    wdata_d    = received_data;
                    addr_d     = addr_inc;
                end
            end
            StRdReq: begin
                state_d = StRdWait;
                if (byte_received) begin
                    addr_d = addr_inc;
                    pend_d = 1'b1;
                end
            end
            StRdWait: begin
                dts_d = reg_rdata;
                if (byte_received || pend_q) begin
                    // A byte arrived mid-fetch: refetch at the advanced address.
                    rd_addr    = byte_received ? addr_inc : addr_q;
                    addr_d     = rd_addr;
                    re_d       = 1'b1;
                    reg_addr_d = rd_addr;
                    pend_d     = 1'b0;
                    state_d    = StRdReq;
                end else begin
                    state_d = StRd;
                end
            end
            StRd: begin
                if (byte_received) begin
                    addr_d     = addr_inc;
                    re_d       = 1'b1;
                    reg_addr_d = addr_inc;
                    state_d    = StRdReq;
                end
            end
            default: state_d = StIdle;
        endcase

        // Frame end overrides the next state after the current byte is processed.
        if (state_q != StIdle) begin
            if (byte_received) cnt_d = cnt_inc;
            if (ssel_s_q) begin
                state_d = StIdle;
                done_d  = byte_received || (cnt_q != 8'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssel_meta_q <= 1'b1;
            ssel_s_q    <= 1'b1;
            state_q     <= StIdle;
            addr_q      <= 7'd0;
            cnt_q       <= 8'd0;
            pend_q      <= 1'b0;
            dts_q       <= 8'd0;
            reg_addr_q  <= 7'd0;
            wdata_q     <= 8'd0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ssel_meta_q <= ssel;
            ssel_s_q    <= ssel_meta_q;
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            dts_q       <= dts_d;
            reg_addr_q  <= reg_addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            done_q      <= done_d;
        end
    end

    assign data_to_send = dts_q;
    assign reg_addr     = reg_addr_q;
    assign reg_wdata    = wdata_q;
    assign reg_we       = we_q;
    assign reg_re       = re_q;
    assign txn_done     = done_q;
    assign busy         = ~ssel_s_q;

endmodule
